// File: rtl/sprite_line_scheduler.sv
// Per-scanline foreground object evaluator: scans OBM in index order, picks up to
// SLOTS objects covering the requested line, and double-buffers the slot set.
module sprite_line_scheduler #(
  parameter int unsigned OBJECTS = 64,
  parameter int unsigned SLOTS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 eval_start,
  input  logic [7:0]           eval_line,
  input  logic                 line_swap,
  output logic [7:0]           obm_addr,
  input  logic [7:0]           obm_data,
  output logic [SLOTS-1:0]     slot_valid,
  output logic [6*SLOTS-1:0]   slot_obma,
  output logic [3*SLOTS-1:0]   slot_row,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int unsigned OBMA_W = 6;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned CNT_W  = $clog2(SLOTS + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR_Y = 3'd1;
  localparam logic [2:0] CMP_Y  = 3'd2;
  localparam logic [2:0] ADDR_A = 3'd3;
  localparam logic [2:0] CAP_A  = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [7:0]              line_q, line_d;
  logic [OBMA_W-1:0]       obma_q, obma_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ROW_W-1:0]        diff_q, diff_d;
  logic [7:0]              addr_q, addr_d;
  logic [SLOTS-1:0]        sh_valid_q, sh_valid_d;
  logic [OBMA_W*SLOTS-1:0] sh_obma_q, sh_obma_d;
  logic [ROW_W*SLOTS-1:0]  sh_row_q, sh_row_d;
  logic                    sh_ovf_q, sh_ovf_d;
  logic [SLOTS-1:0]        act_valid_q, act_valid_d;
  logic [OBMA_W*SLOTS-1:0] act_obma_q, act_obma_d;
  logic [ROW_W*SLOTS-1:0]  act_row_q, act_row_d;
  logic                    act_ovf_q, act_ovf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    underrun_q, underrun_d;

  logic [8:0]              diff_c;
  logic                    hit_c;
  logic                    last_c;
  logic [ROW_W-1:0]        row_c;

  // Next-state, shadow fill and active-set publication
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    obma_d      = obma_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    addr_d      = addr_q;
    sh_valid_d  = sh_valid_q;
    sh_obma_d   = sh_obma_q;
    sh_row_d    = sh_row_q;
    sh_ovf_d    = sh_ovf_q;
    act_valid_d = act_valid_q;
    act_obma_d  = act_obma_q;
    act_row_d   = act_row_q;
    act_ovf_d   = act_ovf_q;
    underrun_d  = 1'b0;

    diff_c = {1'b0, line_q} - {1'b0, obm_data};
    hit_c  = diff_c < 9'd8;
    last_c = obma_q == OBMA_W'(OBJECTS - 1);
    row_c  = obm_data[5] ? (3'd7 - diff_q) : diff_q;

    if (eval_start) begin
      line_d     = eval_line;
      sh_valid_d = '0;
      sh_ovf_d   = 1'b0;
      cnt_d      = '0;
      obma_d     = '0;
      state_d    = ADDR_Y;
    end else begin
      case (state_q)
        IDLE:   state_d = IDLE;
        ADDR_Y: state_d = CMP_Y;
        CMP_Y: begin
          diff_d = diff_c[ROW_W-1:0];
          if (hit_c) begin
            if (cnt_q == CNT_W'(SLOTS)) begin
              sh_ovf_d = 1'b1;
              state_d  = FIN;
            end else begin
              state_d = ADDR_A;
            end
          end else if (last_c) begin
            state_d = FIN;
          end else begin
            obma_d  = obma_q + OBMA_W'(1);
            state_d = ADDR_Y;
          end
        end
        ADDR_A: state_d = CAP_A;
        CAP_A: begin
          for (int k = 0; k < int'(SLOTS); k++) begin
            if (cnt_q == CNT_W'(k)) begin
              sh_valid_d[k]                = 1'b1;
              sh_obma_d[k*OBMA_W +: OBMA_W] = obma_q;
              sh_row_d[k*ROW_W +: ROW_W]    = row_c;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d = FIN;
          end else begin
            obma_d  = obma_q + OBMA_W'(1);
            state_d = ADDR_Y;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == ADDR_Y) begin
      addr_d = {obma_d, 2'd1};
    end else if (state_d == ADDR_A) begin
      addr_d = {obma_q, 2'd2};
    end

    busy_d = state_d != IDLE;
    done_d = state_d == FIN;

    // Swap uses the pre-edge shadow, so a same-cycle eval_start cannot clear what is published
    if (line_swap) begin
      if (busy_q) begin
        act_valid_d = '0;
        act_ovf_d   = 1'b0;
        underrun_d  = 1'b1;
      end else begin
        act_valid_d = sh_valid_q;
        act_obma_d  = sh_obma_q;
        act_row_d   = sh_row_q;
        act_ovf_d   = sh_ovf_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      obma_q      <= '0;
      cnt_q       <= '0;
      diff_q      <= '0;
      addr_q      <= '0;
      sh_valid_q  <= '0;
      sh_obma_q   <= '0;
      sh_row_q    <= '0;
      sh_ovf_q    <= 1'b0;
      act_valid_q <= '0;
      act_obma_q  <= '0;
      act_row_q   <= '0;
      act_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      obma_q      <= obma_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      addr_q      <= addr_d;
      sh_valid_q  <= sh_valid_d;
      sh_obma_q   <= sh_obma_d;
      sh_row_q    <= sh_row_d;
      sh_ovf_q    <= sh_ovf_d;
      act_valid_q <= act_valid_d;
      act_obma_q  <= act_obma_d;
      act_row_q   <= act_row_d;
      act_ovf_q   <= act_ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign obm_addr   = addr_q;
  assign slot_valid = act_valid_q;
  assign slot_obma  = act_obma_q;
  assign slot_row   = act_row_q;
  assign overflow   = act_ovf_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: OBM behavioural RAM, reference line
// model feeding a scoreboard of published slot sets, and scan-latency checks.
module tb_sprite_line_scheduler;

  localparam int unsigned SLOTS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        eval_start;
  logic [7:0]  eval_line;
  logic        line_swap;
  logic [7:0]  obm_addr;
  logic [7:0]  obm_data;
  logic [7:0]  slot_valid;
  logic [47:0] slot_obma;
  logic [23:0] slot_row;
  logic        overflow;
  logic        busy;
  logic        done;
  logic        underrun;

  typedef struct packed {
    logic [7:0]  valid;
    logic [47:0] obma;
    logic [23:0] row;
    logic        ovf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem[256];
  int         total  = 0;
  int         passed = 0;

  sprite_line_scheduler #(.OBJECTS(64), .SLOTS(SLOTS)) dut (
    .clk(clk), .rst(rst), .eval_start(eval_start), .eval_line(eval_line),
    .line_swap(line_swap), .obm_addr(obm_addr), .obm_data(obm_data),
    .slot_valid(slot_valid), .slot_obma(slot_obma), .slot_row(slot_row),
    .overflow(overflow), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read OBM: data follows the address by one cycle
  always @(posedge clk) obm_data <= mem[obm_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_obm();
    for (int i = 0; i < 256; i++) mem[i] = (i % 4 == 1) ? 8'd200 : 8'd0;
  endtask

  // Reference: which objects cover the line, their rows, and how long the scan takes
  task automatic model(input logic [7:0] line, output exp_t e, output int cyc);
    int         cnt;
    logic [8:0] d;
    logic [7:0] attr;
    logic [2:0] r;
    e = '0; cyc = 1; cnt = 0;
    for (int i = 0; i < 64; i++) begin
      d = {1'b0, line} - {1'b0, mem[i*4+1]};
      if (d < 9'd8) begin
        if (cnt == 8) begin
          e.ovf = 1'b1;
          cyc += 2;
          break;
        end
        attr = mem[i*4+2];
        r = attr[5] ? 3'(7 - int'(d[2:0])) : d[2:0];
        e.valid[cnt] = 1'b1;
        e.obma[cnt*6 +: 6] = 6'(i);
        e.row[cnt*3 +: 3] = r;
        cnt++;
        cyc += 4;
      end else begin
        cyc += 2;
      end
    end
  endtask

  task automatic run_eval(input logic [7:0] line, input string tag);
    exp_t e;
    int   cyc_exp;
    int   cyc;
    model(line, e, cyc_exp);
    sb.push_back(e);
    @(negedge clk);
    eval_start = 1'b1;
    eval_line  = line;
    @(negedge clk);
    eval_start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(cyc_exp));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic swap_and_check(input string tag);
    exp_t        e;
    logic [47:0] m6;
    logic [23:0] m3;
    @(negedge clk);
    line_swap = 1'b1;
    @(negedge clk);
    line_swap = 1'b0;
    chk({tag, "_no_underrun"}, 64'(underrun), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      m6 = '0; m3 = '0;
      for (int k = 0; k < 8; k++) begin
        if (e.valid[k]) begin
          m6[k*6 +: 6] = 6'h3f;
          m3[k*3 +: 3] = 3'h7;
        end
      end
      chk({tag, "_valid"}, 64'(slot_valid), 64'(e.valid));
      chk({tag, "_obma"}, 64'(slot_obma & m6), 64'(e.obma));
      chk({tag, "_row"}, 64'(slot_row & m3), 64'(e.row));
      chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
    end
  endtask

  initial begin
    int cyc;
    int dones;
    rst = 1'b1; eval_start = 1'b0; eval_line = '0; line_swap = 1'b0;
    clear_obm();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(slot_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(obm_addr), 64'd0);
    chk("rst_flags", 64'({done, underrun}), 64'd0);
    rst = 1'b0;

    // Single hit at index 5
    mem[5*4+1] = 8'd100;
    run_eval(8'd103, "single");
    chk("single_lat_const", 64'(2*63 + 4 + 1), 64'(131));
    swap_and_check("single");
    chk("single_obma5", 64'(slot_obma[5:0]), 64'd5);
    chk("single_row3", 64'(slot_row[2:0]), 64'd3);

    // vflip on / off
    clear_obm();
    mem[1] = 8'd10; mem[2] = 8'h20;
    run_eval(8'd11, "vflip1");
    swap_and_check("vflip1");
    chk("vflip1_row6", 64'(slot_row[2:0]), 64'd6);
    mem[2] = 8'h00;
    run_eval(8'd11, "vflip0");
    swap_and_check("vflip0");
    chk("vflip0_row1", 64'(slot_row[2:0]), 64'd1);

    // Ten objects on one line: truncation to eight
    clear_obm();
    for (int i = 0; i < 10; i++) mem[i*4+1] = 8'd50;
    run_eval(8'd50, "ovf");
    swap_and_check("ovf");
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_all_valid", 64'(slot_valid), 64'hff);

    // Bottom-edge object, no vertical wrap
    clear_obm();
    mem[3*4+1] = 8'd252;
    run_eval(8'd255, "y252_l255");
    swap_and_check("y252_l255");
    chk("y252_l255_row", 64'(slot_row[2:0]), 64'd3);
    run_eval(8'd2, "y252_l2");
    swap_and_check("y252_l2");
    run_eval(8'd251, "y252_l251");
    swap_and_check("y252_l251");

    // Restart mid-scan: only the restarted scan reports done
    clear_obm();
    mem[7*4+1] = 8'd30; mem[20*4+1] = 8'd28; mem[20*4+2] = 8'h20;
    @(negedge clk);
    eval_start = 1'b1; eval_line = 8'd33;
    @(negedge clk);
    eval_start = 1'b0;
    dones = 0;
    repeat (19) begin
      @(negedge clk);
      if (done) dones++;
    end
    run_eval(8'd33, "restart");
    repeat (150) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("restart_extra_done", 64'(dones), 64'd0);
    swap_and_check("restart");

    // line_swap while busy
    @(negedge clk);
    eval_start = 1'b1; eval_line = 8'd33;
    @(negedge clk);
    eval_start = 1'b0;
    repeat (5) @(negedge clk);
    line_swap = 1'b1;
    @(negedge clk);
    line_swap = 1'b0;
    chk("underrun_pulse", 64'(underrun), 64'd1);
    chk("underrun_valid", 64'(slot_valid), 64'd0);
    chk("underrun_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    chk("underrun_single", 64'(underrun), 64'd0);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("underrun_scan_done", 64'(done), 64'd1);
    @(negedge clk);
    begin
      exp_t e;
      int   c;
      model(8'd33, e, c);
      sb.push_back(e);
    end
    swap_and_check("after_underrun");

    // Reset mid-scan, then a normal evaluation
    @(negedge clk);
    eval_start = 1'b1; eval_line = 8'd33;
    @(negedge clk);
    eval_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 64'(slot_valid), 64'd0);
    chk("midrst_obma", 64'(slot_obma), 64'd0);
    chk("midrst_row", 64'(slot_row), 64'd0);
    chk("midrst_flags", 64'({overflow, busy, done, underrun}), 64'd0);
    chk("midrst_addr", 64'(obm_addr), 64'd0);
    run_eval(8'd33, "post_rst");
    swap_and_check("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline object evaluator for the foreground layer. During each line it walks the 64-entry Object Memory (OBM) in index order and selects up to `SLOTS` objects that cover the next scanline. For each selected object it computes the vflip-corrected pattern row. The result is double-buffered so the foreground renderer always sees a stable slot set for the line being displayed. It sits between the OBM read port and the per-slot foreground pixel pipelines.

## Interface
Parameters:
- `OBJECTS`, 64: objects scanned (OBM entries of 4 bytes).
- `SLOTS`, 8: maximum objects per line.

Ports:
- `clk`  in  1  pixel clock (12.5875 MHz).
- `rst`  in  1  reset, synchronous, active-high.
- `eval_start`  in  1  one-cycle pulse that begins evaluation of `eval_line`.
- `eval_line`  in  8  scanline to evaluate, sampled on `eval_start`.
- `line_swap`  in  1  one-cycle pulse at display-line start; publishes the shadow set.
- `obm_addr`  out  8  OBM read address (`{obma[5:0], byte[1:0]}`).
- `obm_data`  in  8  OBM read data, valid the cycle after `obm_addr`.
- `slot_valid`  out  SLOTS  active slot occupied.
- `slot_obma`  out  6*SLOTS  object index per active slot; slot k is bits [6k+5:6k].
- `slot_row`  out  3*SLOTS  vflip-corrected pattern row per active slot.
- `overflow`  out  1  active set was truncated (more than SLOTS hits).
- `busy`  out  1  evaluation in progress.
- `done`  out  1  one-cycle pulse when evaluation completes.
- `underrun`  out  1  one-cycle pulse when `line_swap` arrives while busy.

## Operation
- FSM states are IDLE, ADDR_Y, CMP_Y, ADDR_A, CAP_A and FIN.
- IDLE: on `eval_start`:
  - latch `eval_line`;
  - clear the shadow valid bits, shadow overflow and the hit count;
  - set obma=0;
  - go to ADDR_Y.
- ADDR_Y: drive `obm_addr={obma,2'd1}` (YP byte), then go to CMP_Y.
- CMP_Y: compute `diff = {1'b0,eval_line} - {1'b0,obm_data}` in 9 bits. The object is a hit iff `diff < 8`.
  - No wrap: an object at Y=252 covers lines 252–255 only.
  - Hit with count < SLOTS: go to ADDR_A.
  - Hit with count == SLOTS: set shadow overflow and go to FIN.
  - Miss with obma == OBJECTS-1: go to FIN.
  - Miss otherwise: obma+1, then go to ADDR_Y.
- ADDR_A: drive `obm_addr={obma,2'd2}` (attribute byte).
- CAP_A: write shadow slot[count]:
  - obma;
  - row = `obm_data[5]` (vflip) ? 7-diff[2:0] : diff[2:0].
  - Then count+1. If obma == OBJECTS-1 go to FIN, else obma+1 and go to ADDR_Y.
- FIN: pulse `done`, return to IDLE.
- Priority: lower obma always takes the lower slot. Slots fill contiguously from 0.
- `eval_start` in any non-IDLE state aborts the scan and restarts it, with the same clearing as from IDLE. No `done` is issued for the aborted scan.
- `line_swap`:
  - Not busy: copy shadow valid/obma/row/overflow into the active outputs.
  - Busy: clear active `slot_valid` and `overflow` to 0 and pulse `underrun`. The shadow set is untouched.
- `line_swap` and `eval_start` in the same cycle while IDLE: the swap publishes the existing shadow; the new scan's clearing takes effect for subsequent cycles.
- `obm_addr` holds its last value in IDLE and FIN.

## Timing
- Reset values: FSM=IDLE; all `slot_*`, `overflow`, `busy`, `done` and `underrun` = 0; `obm_addr`=0; shadow cleared.
- `busy` is high from the cycle after `eval_start` through FIN inclusive.
- Cycle cost per object: a miss costs 2 cycles (ADDR_Y, CMP_Y); a hit costs 4 cycles.
- Total scan time is `2*misses + 4*hits + 1` (FIN) cycles after the `eval_start` edge.
  - Worst case is 2*56 + 4*8 + 1 = 145 cycles, well inside the 400-cycle line.
  - Early overflow termination shortens the scan.
- Active outputs change only on the edge following `line_swap`, and are stable for the whole line.
- `done` and `underrun` are single-cycle pulses.

## Test plan
- Only object 5 has Y=100 (others Y=200), eval_line=103, then `line_swap` -> slot0 valid, obma=5, row=3, other slots invalid, overflow=0. `done` arrives exactly 2*63+4+1=131 cycles after `eval_start`.
- Object 0 with Y=10 and vflip=1, eval_line=11 -> row=6. With vflip=0 -> row=1.
- Objects 0–9 all at Y=50, eval_line=50 -> slots 0–7 hold obma 0–7 and overflow=1. `done` arrives 4*8+2+1=35 cycles after start.
- Object 3 at Y=252:
  - eval_line=255 -> hit, row=3.
  - eval_line=2 -> no hit (no wrap).
  - eval_line=251 -> no hit.
- `eval_start` again 20 cycles into a scan -> first scan produces no `done`; a single `done` follows the full restarted scan with correct slots.
- `line_swap` while busy -> `underrun` pulses, active `slot_valid`=0. The next `line_swap` after `done` publishes the full set.
- `rst` asserted mid-scan -> next cycle all outputs are 0 and FSM is IDLE. A subsequent eval behaves normally.
